// File: rtl/pau_pkg.sv
// Shared types for the PAU issue path: sequencer state and the in-flight tag entry.
package pau_pkg;

    localparam int PAU_TRANS_ID_BITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // killed must stay the LSB: the tag FIFO sets bit 0 to kill an entry.
    typedef struct packed {
        logic [PAU_TRANS_ID_BITS-1:0] trans_id;
        logic                         quire_wr;
        logic                         killed;
    } tag_entry_t;

    localparam int TAG_ENTRY_BITS = $bits(tag_entry_t);

endpackage

// File: rtl/pau_tag_fifo.sv
// In-order tag FIFO for in-flight PAU ops; bit 0 of each entry is its killed flag.
module pau_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             kill_all_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Killing stale slots too is harmless: a push always rewrites the whole entry.
    always_ff @(posedge clk_i) begin
        if (kill_all_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i][0] <= 1'b1;
        end
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/pau_issue_sequencer.sv
// Gates CVA6 issue into the PAU, bounds in-flight ops, orders quire RAW and
// drops write-back of ops killed by a flush.
module pau_issue_sequencer #(
    parameter int TRANS_ID_BITS   = pau_pkg::PAU_TRANS_ID_BITS,
    parameter int XLEN            = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
    input  logic                     req_quire_wr_i,
    input  logic                     req_quire_rd_i,
    output logic                     pau_valid_o,
    output logic [TRANS_ID_BITS-1:0] pau_trans_id_o,
    input  logic                     pau_ready_i,
    input  logic                     pau_res_valid_i,
    input  logic [TRANS_ID_BITS-1:0] pau_res_trans_id_i,
    input  logic [XLEN-1:0]          pau_res_i,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic                     busy_o,
    output logic                     err_o
);
    import pau_pkg::*;

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    seq_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           qwr_cnt_q, qwr_cnt_d;
    logic                    wb_valid_q;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_q;
    logic [XLEN-1:0]         wb_result_q;
    logic                    err_q;

    tag_entry_t head;
    tag_entry_t push_entry;
    logic       fifo_full, fifo_empty;
    logic       accept, pop, res_err, qrd_hazard;

    // A QROUND (or combined rd/wr op) must wait for every older quire writer.
    assign qrd_hazard  = req_quire_rd_i & (qwr_cnt_q != '0);
    assign req_ready_o = pau_ready_i & ~fifo_full & ~flush_i &
                         (state_q != DRAIN) & ~qrd_hazard;
    assign accept      = req_valid_i & req_ready_o;
    assign pop         = pau_res_valid_i & ~fifo_empty;
    assign res_err     = pau_res_valid_i &
                         (fifo_empty | (head.trans_id != pau_res_trans_id_i));

    assign pau_valid_o    = accept;
    assign pau_trans_id_o = req_trans_id_i;

    always_comb begin
        push_entry          = '0;
        push_entry.trans_id = req_trans_id_i;
        push_entry.quire_wr = req_quire_wr_i;
    end

    pau_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_ENTRY_BITS)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .kill_all_i  (flush_i),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        cnt_d     = cnt_q + CW'(accept) - CW'(pop);
        qwr_cnt_d = qwr_cnt_q + CW'(accept & req_quire_wr_i) - CW'(pop & head.quire_wr);
        state_d   = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i)     state_d = (cnt_d != '0) ? DRAIN : IDLE;
                else if (accept) state_d = BUSY;
            end
            BUSY: begin
                if (flush_i)            state_d = (cnt_d != '0) ? DRAIN : IDLE;
                else if (cnt_d == '0)   state_d = IDLE;
            end
            DRAIN: begin
                if (cnt_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            qwr_cnt_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_trans_id_q <= '0;
            wb_result_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qwr_cnt_q  <= qwr_cnt_d;
            err_q      <= err_q | res_err;
            wb_valid_q <= pop & ~head.killed & ~flush_i;
            if (pop) begin
                wb_trans_id_q <= pau_res_trans_id_i;
                wb_result_q   <= pau_res_i;
            end
        end
    end

    assign wb_valid_o    = wb_valid_q;
    assign wb_trans_id_o = wb_trans_id_q;
    assign wb_result_o   = wb_result_q;
    assign busy_o        = (state_q != IDLE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_pau_issue_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_pau_issue_sequencer;

    localparam int IDW  = 3;
    localparam int XL   = 64;
    localparam int MAXO = 4;

    logic           clk_i = 1'b0;
    logic           rst_i, flush_i, req_valid_i, req_quire_wr_i, req_quire_rd_i;
    logic [IDW-1:0] req_trans_id_i, pau_trans_id_o, pau_res_trans_id_i, wb_trans_id_o;
    logic           req_ready_o, pau_valid_o, pau_ready_i, pau_res_valid_i;
    logic [XL-1:0]  pau_res_i, wb_result_o;
    logic           wb_valid_o, busy_o, err_o;

    always #5 clk_i = ~clk_i;

    pau_issue_sequencer #(
        .TRANS_ID_BITS   (IDW),
        .XLEN            (XL),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_trans_id_i     (req_trans_id_i),
        .req_quire_wr_i     (req_quire_wr_i),
        .req_quire_rd_i     (req_quire_rd_i),
        .pau_valid_o        (pau_valid_o),
        .pau_trans_id_o     (pau_trans_id_o),
        .pau_ready_i        (pau_ready_i),
        .pau_res_valid_i    (pau_res_valid_i),
        .pau_res_trans_id_i (pau_res_trans_id_i),
        .pau_res_i          (pau_res_i),
        .wb_valid_o         (wb_valid_o),
        .wb_trans_id_o      (wb_trans_id_o),
        .wb_result_o        (wb_result_o),
        .busy_o             (busy_o),
        .err_o              (err_o)
    );

    // Reference model: ops the PAU still owes a result for, oldest first.
    typedef struct {
        logic [IDW-1:0] id;
        bit             qwr;
        bit             killed;
    } ent_t;

    ent_t           mq[$];
    bit             m_drain, m_err, m_wbv;
    logic [IDW-1:0] m_wbid;
    logic [XL-1:0]  m_wbres;
    int             total = 0;
    int             bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(bit pr, bit qrd, bit fl);
        int nq = 0;
        foreach (mq[i]) if (mq[i].qwr) nq++;
        return pr && (mq.size() < MAXO) && !fl && !m_drain && !(qrd && nq != 0);
    endfunction

    // One clock cycle: drive, check combinational issue path, clock, update model, check registered outputs.
    task automatic step(input bit v, input logic [IDW-1:0] id, input bit qwr, input bit qrd,
                        input bit pr, input bit rv, input logic [IDW-1:0] rid,
                        input logic [XL-1:0] res, input bit fl, input bit rs, output bit acc);
        bit   er;
        ent_t h;
        req_valid_i = v;  req_trans_id_i = id;  req_quire_wr_i = qwr;  req_quire_rd_i = qrd;
        pau_ready_i = pr; pau_res_valid_i = rv; pau_res_trans_id_i = rid; pau_res_i = res;
        flush_i = fl;     rst_i = rs;
        #1;
        er  = model_ready(pr, qrd, fl);
        acc = er && v && !rs;
        if (!rs) begin
            chk("req_ready", 64'(req_ready_o), 64'(er));
            chk("pau_valid", 64'(pau_valid_o), 64'(er && v));
            if (er && v) chk("pau_trans_id", 64'(pau_trans_id_o), 64'(id));
        end
        @(posedge clk_i);
        if (rs) begin
            mq.delete();
            m_drain = 0; m_err = 0; m_wbv = 0; m_wbid = '0; m_wbres = '0;
        end else begin
            m_wbv = 0;
            if (rv) begin
                if (mq.size() == 0) m_err = 1;
                else begin
                    h = mq.pop_front();
                    if (h.id != rid) m_err = 1;
                    m_wbv   = !h.killed && !fl;
                    m_wbid  = rid;
                    m_wbres = res;
                end
            end
            if (fl) foreach (mq[i]) mq[i].killed = 1;
            if (acc) mq.push_back('{id, qwr, 1'b0});
            if (fl && mq.size() != 0) m_drain = 1;
            if (mq.size() == 0) m_drain = 0;
        end
        #1;
        chk("wb_valid", 64'(wb_valid_o), 64'(m_wbv));
        chk("wb_trans_id", 64'(wb_trans_id_o), 64'(m_wbid));
        chk("wb_result", wb_result_o, m_wbres);
        chk("err", 64'(err_o), 64'(m_err));
        chk("busy", 64'(busy_o), 64'(mq.size() != 0));
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        bit a;
        step(0, '0, 0, 0, 1, 0, '0, '0, 0, 1, a);
    endtask

    task automatic issue(input logic [IDW-1:0] id, input bit qwr, input bit qrd);
        bit a;
        step(1, id, qwr, qrd, 1, 0, '0, '0, 0, 0, a);
    endtask

    task automatic result(input logic [IDW-1:0] rid);
        bit a;
        step(0, '0, 0, 0, 1, 1, rid, {$urandom, $urandom}, 0, 0, a);
    endtask

    initial begin
        bit a;
        rst_i = 1; flush_i = 0; req_valid_i = 0; req_trans_id_i = '0;
        req_quire_wr_i = 0; req_quire_rd_i = 0; pau_ready_i = 1;
        pau_res_valid_i = 0; pau_res_trans_id_i = '0; pau_res_i = '0;
        @(negedge clk_i);
        do_reset();

        // Back-to-back PADDs; the 5th is refused.
        for (int i = 1; i <= 5; i++) issue(IDW'(i), 0, 0);
        for (int i = 1; i <= 4; i++) result(IDW'(i));
        issue(3'd0, 0, 0);
        result(3'd0);

        // QROUND waits for the older QMADD to return.
        issue(3'd1, 1, 0);
        step(1, 3'd2, 0, 1, 1, 0, '0, '0, 0, 0, a);
        step(1, 3'd2, 0, 1, 1, 0, '0, '0, 0, 0, a);
        step(1, 3'd2, 0, 1, 1, 1, 3'd1, 64'h1111, 0, 0, a);
        step(1, 3'd2, 0, 1, 1, 0, '0, '0, 0, 0, a);
        result(3'd2);

        // Flush with two in flight, drain, then accept again.
        issue(3'd5, 0, 0);
        issue(3'd6, 1, 0);
        step(1, 3'd7, 0, 0, 1, 0, '0, '0, 1, 0, a);
        issue(3'd7, 0, 0);
        step(1, 3'd7, 0, 0, 1, 1, 3'd5, 64'h5555, 0, 0, a);
        step(1, 3'd7, 0, 0, 1, 1, 3'd6, 64'h6666, 0, 0, a);
        issue(3'd7, 0, 0);
        result(3'd7);

        // Same-cycle push and pop at MAX-1, then fill and overflow attempt.
        issue(3'd2, 0, 0);
        issue(3'd5, 0, 0);
        issue(3'd6, 0, 0);
        step(1, 3'd3, 0, 0, 1, 1, 3'd2, 64'h2222, 0, 0, a);
        issue(3'd4, 0, 0);
        step(1, 3'd1, 0, 0, 1, 1, 3'd5, 64'h5050, 0, 0, a);
        result(3'd6);
        result(3'd3);
        result(3'd4);

        // Protocol errors: wrong ID, then a result with nothing in flight.
        issue(3'd4, 0, 0);
        result(3'd7);
        result(3'd0);
        issue(3'd1, 0, 0);
        result(3'd1);
        do_reset();

        // Reset with ops in flight, then a stray late result.
        issue(3'd1, 1, 0);
        issue(3'd2, 0, 0);
        issue(3'd3, 0, 0);
        do_reset();
        result(3'd2);
        result(3'd3);
        do_reset();

        // Random traffic; results always follow the model's issue order.
        for (int n = 0; n < 3000; n++) begin
            bit             v, qwr, qrd, pr, rv, fl, rs;
            logic [IDW-1:0] id, rid;
            v   = ($urandom % 4) != 0;
            id  = IDW'($urandom);
            qwr = ($urandom % 3) == 0;
            qrd = ($urandom % 4) == 0;
            pr  = ($urandom % 5) != 0;
            rv  = (mq.size() != 0) && ($urandom % 2 == 0);
            rid = (mq.size() != 0) ? mq[0].id : IDW'(0);
            fl  = ($urandom % 25) == 0;
            rs  = ($urandom % 400) == 0;
            step(v, id, qwr, qrd, pr, rv, rid, {$urandom, $urandom}, fl, rs, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pau_issue_sequencer.md
Name: pau_issue_sequencer

Overview:
- Sits between the CVA6 issue stage and the posit arithmetic unit (PAU) wrapper.
- Gates issue into the PAU and bounds the number of in-flight operations.
- Enforces quire read-after-write ordering: QROUND waits for all outstanding quire-writing ops.
- Tracks in-flight transaction IDs in issue order, suppresses write-back of flushed ops, and drains the PAU cleanly after a flush.

Parameters:
- TRANS_ID_BITS, 3, width of transaction ID.
- XLEN, 64, result width.
- MAX_OUTSTANDING, 4, max in-flight PAU ops (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  kill all in-flight ops
- req_valid_i  in  1  issue request
- req_ready_o  out  1  sequencer accepts request
- req_trans_id_i  in  TRANS_ID_BITS  request transaction ID
- req_quire_wr_i  in  1  op writes quire (QMADD/QMSUB/QCLR/QNEG)
- req_quire_rd_i  in  1  op reads quire (QROUND)
- pau_valid_o  out  1  issue strobe to PAU
- pau_trans_id_o  out  TRANS_ID_BITS  ID to PAU
- pau_ready_i  in  1  PAU can accept
- pau_res_valid_i  in  1  PAU result valid
- pau_res_trans_id_i  in  TRANS_ID_BITS  PAU result ID
- pau_res_i  in  XLEN  PAU result
- wb_valid_o  out  1  write-back valid
- wb_trans_id_o  out  TRANS_ID_BITS  write-back ID
- wb_result_o  out  XLEN  write-back data
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, FIFO empty, cnt=0, qwr_cnt=0, state=IDLE, err_o=0. Reset mid-operation discards all tracking. Late PAU results that arrive after reset are treated as "result with empty FIFO" (below).
- The PAU returns exactly one result per accepted op, in issue order. This includes quire writers.
- Accept condition:
  - req_ready_o = pau_ready_i & (cnt < MAX_OUTSTANDING) & ~flush_i & state != DRAIN & ~(req_quire_rd_i & qwr_cnt != 0).
  - cnt is the registered count. A same-cycle pop does not free a slot.
- Issue:
  - pau_valid_o = req_valid_i & req_ready_o.
  - pau_trans_id_o = req_trans_id_i. This path is combinational.
  - On accept, push {trans_id, quire_wr, killed=0} into the tag FIFO, cnt+1, and qwr_cnt+1 if quire_wr.
- Result:
  - On pau_res_valid_i, pop the FIFO head, cnt-1, and qwr_cnt-1 if the head has quire_wr.
  - If head.trans_id != pau_res_trans_id_i, set err_o (sticky until reset). The pop still happens.
  - If the FIFO is empty, set err_o. Nothing pops and no write-back occurs.
- Write-back:
  - Registered, 1-cycle latency from the result.
  - wb_valid_o = pop & ~head.killed & ~flush_i.
  - wb_trans_id_o and wb_result_o are captured on every valid pop; they hold their value otherwise.
  - wb_valid_o is a single-cycle pulse. Write-back has no backpressure.
- Simultaneous push and pop: allowed. cnt and qwr_cnt net correctly (+1-1 = 0).
- Flush:
  - Sets killed on every FIFO entry, including the entry popped that cycle.
  - Blocks acceptance that cycle.
  - Killed quire writers still decrement qwr_cnt on return. Quire contents are not restored.
- States:
  - IDLE -> BUSY on accept.
  - BUSY -> IDLE when next cnt = 0.
  - IDLE/BUSY -> DRAIN on flush_i when next cnt != 0.
  - DRAIN -> IDLE when next cnt = 0.
  - Flush with next cnt = 0 stays in, or goes to, IDLE.
  - DRAIN ignores further flush_i and does not accept requests.
- Counters:
  - cnt is clog2(MAX_OUTSTANDING)+1 bits; qwr_cnt is the same width.
  - FIFO pointers have one extra wrap bit. Full is cnt == MAX_OUTSTANDING; empty is cnt == 0.
- A request with both quire_rd and quire_wr is treated as a reader for the hazard check and as a writer for counting.

Decomposition:
- Add to pau_pkg:
  - seq_state_e (IDLE, BUSY, DRAIN).
  - tag_entry_t {trans_id, quire_wr, killed}, parameterized via TRANS_ID_BITS.
- Sub-module pau_tag_fifo:
  - Parameterized depth/width, push/pop, plus a kill_all input that sets killed on every valid entry.
  - Exposes its head entry, full and empty.

Test Plan:
- Back-to-back PADD IDs 1,2,3,4 with pau_ready_i=1: 5th request is refused (ready=0). Results for IDs 1..4 give wb_valid_o pulses one cycle after each result with IDs 1..4. Afterwards cnt=0 and busy_o=0.
- Issue QMADD id=1, then QROUND id=2 requested next cycle: ready stays 0 until the QMADD result returns. QROUND is accepted the cycle after qwr_cnt reaches 0. Write-back order is 1, 2.
- Issue ids 5,6, then assert flush_i for one cycle: state=DRAIN and ready=0. Results for 5 and 6 produce no wb_valid_o. After the 2nd result, state=IDLE and the next request is accepted.
- Accept id=3 in the same cycle the result for id=2 returns with cnt=MAX_OUTSTANDING-1: cnt stays at MAX_OUTSTANDING-1. wb for id 2 is 1 cycle later.
- Result with trans_id=7 while the head is 4, and separately a result with the FIFO empty: err_o=1 and stays 1 until rst_i. No wb_valid_o in the empty case.
- Assert rst_i with 3 ops in flight: next cycle all outputs are 0 and state=IDLE. A subsequent stray result sets err_o.
